// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART sender among NUM_REQ requesters.
// The sender has no busy output, so each frame and the idle gap after it are timed here.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 7,
    parameter int FRAME_CYCLES = 10,
    parameter int GAP_CYCLES   = 1,
    parameter int ID_W         = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      send_flag,
    output logic [DATA_W-1:0]         send_data,
    output logic                      busy,
    output logic [ID_W-1:0]           active_id
);

    localparam int CNT_MAX = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [ID_W-1:0]  LAST_ID    = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    state_t               r_state,     w_state_nxt;
    logic [CNT_W-1:0]     r_cnt,       w_cnt_nxt;
    logic [ID_W-1:0]      r_ptr,       w_ptr_nxt;
    logic [NUM_REQ-1:0]   r_grant,     w_grant_nxt;
    logic                 r_send_flag, w_flag_nxt;
    logic [DATA_W-1:0]    r_send_data, w_data_nxt;
    logic                 r_busy,      w_busy_nxt;
    logic [ID_W-1:0]      r_active_id, w_id_nxt;

    logic                 w_arb;
    logic                 w_found;
    logic [ID_W-1:0]      w_winner;
    logic [ID_W-1:0]      w_idx;
    logic [DATA_W-1:0]    w_win_data;
    int                   w_sum;

    // Search ptr, ptr+1, ... with wrap-around; the first requester found wins.
    always_comb begin
        // NOTE: every variable gets a default before any branch, otherwise
        // paths that skip an assignment infer a latch.
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        w_sum    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = int'(r_ptr) + k;
            if (w_sum >= NUM_REQ) begin
                w_sum = w_sum - NUM_REQ;
            end
            w_idx = ID_W'(w_sum);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == w_winner) begin
                w_win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = '0;
        w_flag_nxt  = 1'b0;
        w_data_nxt  = r_send_data;
        w_id_nxt    = r_active_id;
        w_busy_nxt  = r_busy;
        w_arb       = 1'b0;

        case (r_state)
            S_IDLE: w_arb = 1'b1;
            S_SEND: begin
                if (r_cnt == FRAME_LAST) begin
                    // With no gap configured, the last frame cycle is itself an arbitration edge.
                    if (GAP_CYCLES > 0) begin
                        w_state_nxt = S_GAP;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_arb = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_arb = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_arb) begin
            if (w_found) begin
                w_state_nxt           = S_SEND;
                w_cnt_nxt             = '0;
                w_grant_nxt[w_winner] = 1'b1;
                w_flag_nxt            = 1'b1;
                w_data_nxt            = w_win_data;
                w_id_nxt              = w_winner;
                w_busy_nxt            = 1'b1;
                w_ptr_nxt             = (w_winner == LAST_ID) ? '0 : w_winner + ID_W'(1);
            end else begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_send_flag <= 1'b0;
            r_send_data <= '0;
            r_busy      <= 1'b0;
            r_active_id <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ptr       <= w_ptr_nxt;
            r_grant     <= w_grant_nxt;
            r_send_flag <= w_flag_nxt;
            r_send_data <= w_data_nxt;
            r_busy      <= w_busy_nxt;
            r_active_id <= w_id_nxt;
        end
    end

    assign grant     = r_grant;
    assign send_flag = r_send_flag;
    assign send_data = r_send_data;
    assign busy      = r_busy;
    assign active_id = r_active_id;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART `sender` between NUM_REQ requesters.
- Accepts 7-bit words from requesters and drives the sender's flag/data inputs, one frame at a time.
- Times each frame with an internal counter, because the sender has no busy output.
- Sits directly in front of `sender`, in the sender clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 7, word width; matches the sender data port.
- FRAME_CYCLES, 10, clk cycles one sender frame occupies (start + 7 data + parity/stop); must be ≥2.
- GAP_CYCLES, 1, idle clk cycles forced between frames; 0 allowed.
- ID_W, 2, width of active_id; must be ≥ clog2(NUM_REQ).

Ports:
- clk, input, 1, system clock; same clock as the sender.
- rst, input, 1, asynchronous active-high reset.
- req, input, NUM_REQ, per-requester level request.
- req_data, input, NUM_REQ*DATA_W, requester i's word in bits [i*DATA_W +: DATA_W].
- grant, output, NUM_REQ, one-hot, 1-cycle pulse: requester's word has been captured.
- send_flag, output, 1, to sender flag; 1-cycle pulse starts a frame.
- send_data, output, DATA_W, to sender data; held stable for the whole frame.
- busy, output, 1, high while a frame or gap is in progress.
- active_id, output, ID_W, index of the requester whose frame is on the line.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; grant=0, send_flag=0, send_data=0, busy=0, active_id=0.
  - Round-robin pointer ptr=0; frame counter=0.
- States: IDLE, SEND, GAP. All outputs are registered.
- Arbitration happens at a clock edge when either:
  - state=IDLE, or
  - it is the final cycle of SEND (GAP_CYCLES=0), or
  - it is the final cycle of GAP.
- At that edge, winner = first i with req[i]=1, searching ptr, ptr+1, …, NUM_REQ-1, 0, … (wrap-around).
- If there is a winner, at that edge:
  - send_data <= req_data[winner]; active_id <= winner.
  - grant[winner] <= 1 and send_flag <= 1, for exactly one cycle.
  - busy <= 1; ptr <= (winner+1) mod NUM_REQ; state <= SEND; counter <= 0.
- If there is no winner: state <= IDLE, busy <= 0, ptr unchanged.
- Latency: req sampled high at edge E in IDLE → grant, send_flag and busy high in the cycle after E.
- SEND:
  - Lasts exactly FRAME_CYCLES cycles, counted from the send_flag cycle.
  - send_data and active_id are frozen.
  - req changes are ignored.
- GAP:
  - Lasts GAP_CYCLES cycles; busy stays 1; send_data holds its last value.
  - When GAP_CYCLES=0, SEND hands straight to arbitration: back-to-back frames, with send_flag at exactly FRAME_CYCLES spacing.
- busy drops only on return to IDLE. With continuous requests, busy stays 1 across frames.
- Requester rules:
  - req_data must be stable whenever req is high.
  - After grant, a requester may keep req high for another word. It is then lowest priority in the next round.
  - If req falls before a grant, no grant is issued and no side effects occur.
- Simultaneous requests: exactly one grant per arbitration. grant is never multi-hot.
- Reset during SEND or GAP:
  - All outputs clear at once; the frame is aborted.
  - The next frame starts only after rst deasserts and an arbitration edge occurs.
- A req asserted during SEND/GAP waits; it is never lost while held.

Test Plan:
- Single request, FRAME_CYCLES=10, GAP_CYCLES=1:
  - req[2]=1 with data 7'h55 at edge E → in cycle E+1, grant=4'b0100, send_flag=1, send_data=7'h55, active_id=2.
  - busy high for 11 cycles, then IDLE.
- All four requesting continuously, words 0x11/0x22/0x33/0x44:
  - grant order 0,1,2,3,0.
  - send_flag pulses spaced 11 cycles apart.
  - send_data follows the same order.
- GAP_CYCLES=0, req[1] and req[3] held high:
  - frames alternate 1,3,1.
  - send_flag exactly 10 cycles apart; busy never drops.
- Pointer wrap: ptr=3 after granting req[2]; req[0] and req[3] asserted together → req[3] is granted first, then req[0].
- Reset mid-frame: rst pulsed in the 5th SEND cycle →
  - same cycle: busy=0, send_data=0, active_id=0.
  - after release with req[1]=1: next grant is req[1], with ptr effectively restarting from 0.
- Dropped request: req[0] pulsed high for 3 cycles during another frame's SEND, then low before arbitration → no grant[0]; state returns to IDLE.
